stream_mux_rr: RTL

- Parametrised N:1 streaming multiplexer. Successor to the fixed 4:1 combinational bus mux.
- Selects among NUM_IN valid/ready input channels using round-robin or fixed-priority arbitration.
- Registers the winning beat into a single-entry output stage, which gives a 1-cycle latency and a clean timing boundary.
- Sits between multiple producers (e.g. datapath units) and one shared consumer bus.

---
 rtl/stream_mux_rr.sv | 133 +++++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream multiplexer with round-robin or
// fixed-priority arbitration and a single registered output stage.
// Ports: clk, rst (synchronous, active-high);
//   in_data/in_valid/in_ready : NUM_IN producer channels (flattened data);
//   out_data/out_valid/out_ready/out_sel : registered beat to the consumer.
// Optional macro STREAM_MUX_LOCK_EN adds in_last/out_last and holds the
// grant on one channel until it sends the last beat of a packet.
module stream_mux_rr #(
    parameter int BUS_WIDTH = 32,
    parameter int NUM_IN    = 4,
    parameter int ARB_MODE  = 0,
    parameter int SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN*BUS_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]           in_valid,
    output logic [NUM_IN-1:0]           in_ready,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SEL_W-1:0]            out_sel
`ifdef STREAM_MUX_LOCK_EN
    ,
    input  logic [NUM_IN-1:0]           in_last,
    output logic                        out_last
`endif
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     idx;
    logic [SEL_W-1:0]     gidx;
    logic [SEL_W-1:0]     gidx_inc;
    logic                 any_valid;
    logic                 load;
    logic                 xfer;
    logic                 adv_ptr;
    logic [NUM_IN-1:0]    grant;
    logic [BUS_WIDTH-1:0] win_data;

`ifdef STREAM_MUX_LOCK_EN
    logic                 locked;
    logic [SEL_W-1:0]     lock_ch;
`endif

    // Output stage can take a new beat when empty or draining this cycle.
    assign load = ~out_valid | out_ready;

    // Circular search from ptr (round-robin) or from 0 (fixed priority).
    always_comb begin
        idx       = (ARB_MODE == 0) ? ptr : '0;
        any_valid = 1'b0;
        gidx      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!any_valid && in_valid[idx]) begin
                any_valid = 1'b1;
                gidx      = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
        end
`ifdef STREAM_MUX_LOCK_EN
        // Mid-packet: only the owning channel may be granted.
        if (locked) begin
            gidx      = lock_ch;
            any_valid = in_valid[lock_ch];
        end
`endif
    end

    always_comb begin
        grant = '0;
        if (any_valid) begin
            grant = NUM_IN'(1) << gidx;
        end
    end

    assign in_ready = (load && !rst) ? grant : '0;
    assign xfer     = any_valid & load & ~rst;
    assign gidx_inc = (gidx == LAST_IDX) ? '0 : gidx + SEL_W'(1);

`ifdef STREAM_MUX_LOCK_EN
    assign adv_ptr = xfer & in_last[gidx];
`else
    assign adv_ptr = xfer;
`endif

    // Data select driven by the one-hot grant to avoid a wide index mux.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                win_data = in_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_sel   <= gidx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (adv_ptr && (ARB_MODE == 0)) begin
                ptr <= gidx_inc;
            end
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            locked   <= 1'b0;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            locked   <= ~in_last[gidx];
            lock_ch  <= gidx;
            out_last <= in_last[gidx];
        end
    end
`endif

endmodule
